uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver. Direct downstream partner of uart_transmitter; its RxD is wired to the transmitter's TxD for loopback.
- Recovers 11-bit frames: start(0), 8 data bits LSB-first, even parity, stop(1).
- Presents the byte on Rx_DATA with a one-cycle Rx_VALID strobe. Flags framing and parity errors.
- Baud selection uses the same 3-bit baud_select encoding as the transmitter.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency used to compute the divisor table.
- OVERSAMPLE, 16, sample ticks per bit period.
- SYNC_STAGES, 2, flip-flops in the RxD metastability synchronizer.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- baud_select  input  3  000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
- Rx_EN  input  1  receiver enable.
- RxD  input  1  serial line, idle high.
- Rx_DATA  output  8  last received byte.
- Rx_VALID  output  1  one-cycle strobe: good byte on Rx_DATA.
- Rx_FERROR  output  1  framing error: stop bit sampled 0.
- Rx_PERROR  output  1  parity error: even-parity mismatch.

Behaviour:
- Reset (reset=0, asynchronous):
  - Rx_DATA=8'h00; Rx_VALID=0; Rx_FERROR=0; Rx_PERROR=0.
  - FSM=IDLE; all counters 0; synchronizer flops preset to 1.
- Sample tick: one-cycle pulse every DIV clocks. DIV=round(CLK_FREQ_HZ/(OVERSAMPLE*baud)). At 50 MHz:
  - 10417, 2604, 651, 326, 163, 81, 54, 27.
- baud_select is latched on entry to START. Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Waits for synchronized RxD=0 with Rx_EN=1, then moves to START and zeroes the tick counter.
- START:
  - At tick 8, RxD=1 is a glitch: return to IDLE, no flags.
  - At tick 8, RxD=0: clear Rx_FERROR/Rx_PERROR and restart the tick count for bit sampling.
- DATA:
  - Samples each bit at mid-bit (tick 8 of 16) into a shift register, LSB first.
  - After bit 7, goes to PARITY.
- PARITY:
  - Samples the parity bit and computes XOR of data bits ^ parity. Nonzero means parity error (held internally).
- STOP:
  - Samples the stop bit at mid-bit. Same cycle:
    - Rx_DATA <= shift register (always updated).
    - Rx_FERROR <= (stop==0).
    - Rx_PERROR <= internal parity error.
    - Rx_VALID=1 for exactly one clk, only if both errors are 0.
  - Returns to IDLE immediately at mid-stop so back-to-back frames are caught.
- Rx_FERROR and Rx_PERROR stay asserted until the next confirmed start bit, or reset.
- Rx_EN=0 in any state: next clk goes to IDLE and clears counters. Rx_DATA and error flags hold; Rx_VALID=0.
- Reset mid-frame: everything returns to reset values. No partial byte is ever presented.
- Latency: Rx_VALID rises 1 clk after the mid-stop sample tick, plus synchronizer delay of SYNC_STAGES clk after the line edge.

Optional Feature:
- Macro: RX_MAJORITY_VOTE_EN.
- Defined: every bit (start, data, parity, stop) is the 2-of-3 majority of samples at ticks 7, 8, 9. Decisions are taken at tick 9.
- Undefined: single sample at tick 8. Decision timing shifts 1 tick earlier.
- Interface identical in both cases.

Decomposition:
- Package uart_pkg (shared with the transmitter):
  - baud divisor constants indexed by baud_select;
  - frame constants: DATA_BITS=8, even-parity selector, OVERSAMPLE;
  - receiver FSM state encoding.
- Sub-module baud_controller: takes baud_select (latched), produces the one-cycle sample tick. Same block the transmitter instantiates, with OVERSAMPLE-scaled divisors.

Test Plan:
- Reset: hold reset=0 for 400 ns with RxD toggling. All outputs 0; no Rx_VALID after release with RxD=1.
- Loopback at baud_select=3'b111 (DIV=27, bit=432 clk=8640 ns):
  - transmitter sends 8'h17 (parity bit 0) into RxD.
  - Expect Rx_DATA=8'h17 and Rx_VALID for exactly 1 clk, ~10.5 bit times after the start edge. Flags 0.
- Parity error: drive frame data 8'hA5 with parity bit 1 (correct is 0) at 9600 (DIV=326).
  - Expect Rx_PERROR=1, Rx_DATA=8'hA5, Rx_VALID never asserted.
- Framing error: send 8'h3C with stop bit 0 at 115200.
  - Expect Rx_FERROR=1 and no Rx_VALID.
  - Then send a valid 8'h55: both flags clear at its start bit; Rx_VALID pulses with 8'h55.
- Glitch and enable:
  - A 3 µs low pulse on idle RxD at 115200 causes no activity.
  - Drop Rx_EN mid-DATA of frame 8'hF0: no Rx_VALID, FSM back to IDLE.
  - A following frame 8'h0F is received correctly.
- Back-to-back: 4 frames 8'h00, 8'hFF, 8'h81, 8'h7E with zero idle gap at 57600 (DIV=54).
  - Exactly 4 Rx_VALID strobes, in order. Repeat with RX_MAJORITY_VOTE_EN defined.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: baud divisor table, 8E1 frame format and receiver state encoding.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int          DATA_BITS       = 8;
    // Parity selector: 0 = even parity, 1 = odd parity.
    localparam logic        PARITY_ODD      = 1'b0;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic int unsigned baud_rate(input logic [2:0] sel);
        case (sel)
            3'd0:    return 300;
            3'd1:    return 1200;
            3'd2:    return 4800;
            3'd3:    return 9600;
            3'd4:    return 19200;
            3'd5:    return 38400;
            3'd6:    return 57600;
            default: return 115200;
        endcase
    endfunction

    // Rounded divisor from system clock to one oversample tick.
    function automatic logic [15:0] baud_div(input int unsigned clk_hz,
                                             input int unsigned os,
                                             input logic [2:0]  sel);
        int unsigned den;
        den = os * baud_rate(sel);
        return 16'((clk_hz + den / 2) / den);
    endfunction

endpackage

// File: rtl/baud_controller.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase restarted while clear is high.
module baud_controller
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [2:0] baud_select,
    output logic       tick
);

    logic [15:0] div_table [8];
    logic [15:0] cnt_q;

    // Divisors are elaboration-time constants; only a mux remains in hardware.
    for (genvar g = 0; g < 8; g++) begin : g_div
        localparam logic [15:0] DIV = baud_div(CLK_FREQ_HZ, OVERSAMPLE, 3'(g));
        assign div_table[g] = DIV;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || cnt_q == '0) begin
            cnt_q <= div_table[baud_select] - 16'd1;
        end else begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

    assign tick = !clear && (cnt_q == '0);

endmodule

// File: rtl/uart_receiver.sv
// 8E1 UART receiver with oversampled bit recovery, framing/parity flags and a one-cycle valid strobe.
// Build option RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 vote of ticks 7/8/9 instead of tick 8 alone.
//   state     | meaning
//   RX_IDLE   | line idle, waiting for a low level while Rx_EN is high
//   RX_START  | confirming the start bit at mid-bit (high there = glitch)
//   RX_DATA   | shifting in data bits, LSB first
//   RX_PARITY | sampling the even-parity bit
//   RX_STOP   | sampling the stop bit, presenting byte and flags
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_FERROR,
    output logic       Rx_PERROR
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    typedef logic [OS_W-1:0] os_t;
    localparam os_t OS_LAST = os_t'(OVERSAMPLE - 1);

    rx_state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    logic [2:0]             baud_q, baud_eff;
    logic                   tick, decide, bit_val;
    os_t                    os_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   perr_q;
    logic                   start_ok, take_data, take_parity, take_stop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
    end
    assign rxd_s = sync_q[SYNC_STAGES-1];

    // While idle the divider tracks the live selection so the first tick of a frame already uses it.
    assign baud_eff = (state_q == RX_IDLE) ? baud_select : baud_q;

    baud_controller #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .OVERSAMPLE  (OVERSAMPLE)
    ) u_baud (
        .clk         (clk),
        .rst_n       (reset),
        .clear       (state_q == RX_IDLE),
        .baud_select (baud_eff),
        .tick        (tick)
    );

`ifdef RX_MAJORITY_VOTE_EN
    localparam int DECIDE_AT = OVERSAMPLE / 2 + 1;
    logic [1:0] vote_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vote_q <= '0;
        end else if (tick && (os_cnt == os_t'(DECIDE_AT - 3) || os_cnt == os_t'(DECIDE_AT - 2))) begin
            vote_q <= {vote_q[0], rxd_s};
        end
    end
    assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxd_s) | (vote_q[0] & rxd_s);
`else
    localparam int DECIDE_AT = OVERSAMPLE / 2;
    assign bit_val = rxd_s;
`endif

    // os_cnt wraps once per bit, so the mid-bit decision recurs at the same count for every bit.
    assign decide = tick && (os_cnt == os_t'(DECIDE_AT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RX_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start_ok    = 1'b0;
        take_data   = 1'b0;
        take_parity = 1'b0;
        take_stop   = 1'b0;
        if (!Rx_EN) begin
            state_d = RX_IDLE;
        end else begin
            case (state_q)
                RX_IDLE: if (!rxd_s) state_d = RX_START;
                RX_START: begin
                    if (decide) begin
                        if (bit_val) begin
                            state_d = RX_IDLE;
                        end else begin
                            state_d  = RX_DATA;
                            start_ok = 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (decide) begin
                        take_data = 1'b1;
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    if (decide) begin
                        take_parity = 1'b1;
                        state_d     = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (decide) begin
                        take_stop = 1'b1;
                        state_d   = RX_IDLE;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_q    <= '0;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            Rx_DATA   <= 8'h00;
            Rx_VALID  <= 1'b0;
            Rx_FERROR <= 1'b0;
            Rx_PERROR <= 1'b0;
        end else begin
            Rx_VALID <= 1'b0;
            if (state_q == RX_IDLE && state_d == RX_START) baud_q <= baud_select;

            if (state_q == RX_IDLE || state_d == RX_IDLE) begin
                os_cnt  <= '0;
                bit_cnt <= '0;
            end else if (tick) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
            end

            if (take_data) begin
                shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (start_ok) begin
                Rx_FERROR <= 1'b0;
                Rx_PERROR <= 1'b0;
            end
            if (take_parity) perr_q <= (^{shift_q, bit_val}) ^ PARITY_ODD;
            if (take_stop) begin
                Rx_DATA   <= shift_q;
                Rx_FERROR <= ~bit_val;
                Rx_PERROR <= perr_q;
                Rx_VALID  <= bit_val & ~perr_q;
            end
        end
    end

endmodule
